// File: rtl/sdp_mrdma_ig_req.sv
// sdp_mrdma_ig_req: walks the source cube and issues 32-byte-atom read requests,
// forking each request with a matching context-queue entry.
module sdp_mrdma_ig_req (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        op_load,
    output logic        ig_done,
    input  logic [31:0] reg2dp_src_base_addr_high,
    input  logic [31:0] reg2dp_src_base_addr_low,
    input  logic [31:0] reg2dp_src_line_stride,
    input  logic [31:0] reg2dp_src_surface_stride,
    input  logic [12:0] reg2dp_width,
    input  logic [12:0] reg2dp_height,
    input  logic [12:0] reg2dp_channel,
    input  logic [1:0]  reg2dp_in_precision,
    output logic [78:0] dma_rd_req_pd,
    output logic        dma_rd_req_vld,
    input  logic        dma_rd_req_rdy,
    output logic [13:0] ig2cq_pd,
    output logic        ig2cq_pvld,
    input  logic        ig2cq_prdy
);
    localparam int MAX_BURST = 8;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [12:0] width_r, height_r, line, surf, surf_last;
    logic [31:0] line_stride, surf_stride;
    logic [63:0] line_base, surf_base, addr;
    logic [13:0] x, rem;
    logic [3:0]  atoms, atoms_m1;
    logic        req_acc, cq_acc, req_fire, cq_fire, cmd_done, run;
    logic        eol, eos, eoc;

    always_comb begin
        run       = state == RUN;
        rem       = {1'b0, width_r} + 14'd1 - x;
        eol       = rem <= 14'(MAX_BURST);
        atoms     = eol ? rem[3:0] : 4'(MAX_BURST);
        atoms_m1  = atoms - 4'd1;
        eos       = eol && line == height_r;
        eoc       = eos && surf == surf_last;
        addr      = line_base + {45'b0, x, 5'b0};
        dma_rd_req_vld = run && !req_acc;
        ig2cq_pvld     = run && !cq_acc;
        req_fire  = dma_rd_req_vld && dma_rd_req_rdy;
        cq_fire   = ig2cq_pvld && ig2cq_prdy;
        // a command completes once both sides have fired, in any cycle order
        cmd_done  = run && (req_acc || req_fire) && (cq_acc || cq_fire);
        dma_rd_req_pd = run ? {11'b0, atoms_m1, addr} : 79'b0;
        ig2cq_pd      = run ? {8'b0, eoc, eos, eol, atoms_m1[2:0]} : 14'b0;
        state_nxt = state;
        if (!run && op_load)
            state_nxt = RUN;
        else if (cmd_done && eoc)
            state_nxt = IDLE;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ig_done     <= 1'b0;
            width_r     <= '0;
            height_r    <= '0;
            surf_last   <= '0;
            line_stride <= '0;
            surf_stride <= '0;
            line_base   <= '0;
            surf_base   <= '0;
            x           <= '0;
            line        <= '0;
            surf        <= '0;
            req_acc     <= 1'b0;
            cq_acc      <= 1'b0;
        end else begin
            ig_done <= cmd_done && eoc;
            if (!run && op_load) begin
                width_r     <= reg2dp_width;
                height_r    <= reg2dp_height;
                surf_last   <= reg2dp_in_precision == 2'd0 ? reg2dp_channel >> 5 : reg2dp_channel >> 4;
                line_stride <= reg2dp_src_line_stride & 32'hFFFF_FFE0;
                surf_stride <= reg2dp_src_surface_stride & 32'hFFFF_FFE0;
                line_base   <= {reg2dp_src_base_addr_high, reg2dp_src_base_addr_low & 32'hFFFF_FFE0};
                surf_base   <= {reg2dp_src_base_addr_high, reg2dp_src_base_addr_low & 32'hFFFF_FFE0};
                x           <= '0;
                line        <= '0;
                surf        <= '0;
                req_acc     <= 1'b0;
                cq_acc      <= 1'b0;
            end else if (cmd_done) begin
                req_acc <= 1'b0;
                cq_acc  <= 1'b0;
                if (!eol) begin
                    x <= x + 14'(atoms);
                end else if (!eos) begin
                    x         <= '0;
                    line      <= line + 13'd1;
                    line_base <= line_base + {32'b0, line_stride};
                end else if (!eoc) begin
                    x         <= '0;
                    line      <= '0;
                    surf      <= surf + 13'd1;
                    surf_base <= surf_base + {32'b0, surf_stride};
                    line_base <= surf_base + {32'b0, surf_stride};
                end
            end else begin
                if (req_fire) req_acc <= 1'b1;
                if (cq_fire)  cq_acc  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdp_mrdma_ig_req.sv
// tb_sdp_mrdma_ig_req: directed table plus randomized cubes checked against a
// nested-loop model of the cube walk.
module tb_sdp_mrdma_ig_req;
    logic        clk = 1'b0, rstn = 1'b0, op_load = 1'b0, ig_done;
    logic [31:0] hi = '0, lo = '0, ls = '0, ss = '0;
    logic [12:0] w = '0, h = '0, c = '0;
    logic [1:0]  p = '0;
    logic [78:0] req_pd;
    logic        req_vld, req_rdy = 1'b0;
    logic [13:0] cq_pd;
    logic        cq_vld, cq_rdy = 1'b0;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, last_fire = -10;
    logic [78:0] exp_req[$], got_req[$];
    logic [13:0] exp_cq[$], got_cq[$];
    logic        p_rv = 0, p_rr = 0, p_cv = 0, p_cr = 0;
    logic [78:0] p_rpd;
    logic [13:0] p_cpd;

    sdp_mrdma_ig_req dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .op_load(op_load), .ig_done(ig_done),
        .reg2dp_src_base_addr_high(hi), .reg2dp_src_base_addr_low(lo),
        .reg2dp_src_line_stride(ls), .reg2dp_src_surface_stride(ss),
        .reg2dp_width(w), .reg2dp_height(h), .reg2dp_channel(c), .reg2dp_in_precision(p),
        .dma_rd_req_pd(req_pd), .dma_rd_req_vld(req_vld), .dma_rd_req_rdy(req_rdy),
        .ig2cq_pd(cq_pd), .ig2cq_pvld(cq_vld), .ig2cq_prdy(cq_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (p_rv && !p_rr && req_vld) check("req_pd_stable", 128'(req_pd), 128'(p_rpd));
            if (p_cv && !p_cr && cq_vld)  check("cq_pd_stable", 128'(cq_pd), 128'(p_cpd));
            if (req_vld && req_rdy) begin got_req.push_back(req_pd); last_fire = cyc; end
            if (cq_vld && cq_rdy)   begin got_cq.push_back(cq_pd);   last_fire = cyc; end
            p_rv = req_vld; p_rr = req_rdy; p_rpd = req_pd;
            p_cv = cq_vld;  p_cr = cq_rdy;  p_cpd = cq_pd;
        end else begin
            p_rv = 0; p_cv = 0;
        end
    end

    // expected command stream straight from the cube geometry
    task automatic build_model();
        logic [63:0] base, a;
        logic [31:0] lsm, ssm;
        int slast, n;
        bit eol, eos, eoc;
        exp_req.delete(); exp_cq.delete();
        base  = {hi, lo & 32'hFFFF_FFE0};
        lsm   = ls & 32'hFFFF_FFE0;
        ssm   = ss & 32'hFFFF_FFE0;
        slast = (p == 0) ? int'(c) / 32 : int'(c) / 16;
        for (int s = 0; s <= slast; s++)
            for (int l = 0; l <= int'(h); l++)
                for (int xx = 0; xx <= int'(w); xx += 8) begin
                    n   = (int'(w) + 1 - xx < 8) ? int'(w) + 1 - xx : 8;
                    eol = xx + 8 > int'(w);
                    eos = eol && l == int'(h);
                    eoc = eos && s == slast;
                    a   = base + 64'(s) * 64'(ssm) + 64'(l) * 64'(lsm) + 64'(xx) * 64'd32;
                    exp_req.push_back({15'(n - 1), a});
                    exp_cq.push_back({8'b0, eoc, eos, eol, 3'(n - 1)});
                end
    endtask

    // mode: 0 both ready, 1 random, 2 request ready held low 5 cycles, 3 cq ready held low 5 cycles
    task automatic run_job(input int mode, input bit busy);
        bit done = 0;
        build_model();
        got_req.delete(); got_cq.delete();
        @(posedge clk); #1 op_load = 1;
        @(posedge clk); #1 op_load = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            req_rdy = mode == 1 ? 1'($urandom) : mode == 2 ? (i >= 5) : 1'b1;
            cq_rdy  = mode == 1 ? 1'($urandom) : mode == 3 ? (i >= 5) : 1'b1;
            if (busy && i == 2) begin op_load = 1; lo = lo ^ 32'h1000; end
            if (busy && i == 3) op_load = 0;
            @(negedge clk);
            if (i == 0) check("start_valids", {req_vld, cq_vld}, 2'b11);
            if (ig_done) begin
                done = 1;
                check("done_latency", cyc, last_fire + 1);
                check("done_valids_low", {req_vld, cq_vld}, 2'b00);
            end else begin
                @(posedge clk); #1;
            end
        end
        op_load = 0;
        if (!done) check("ig_done_timeout", 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_one_pulse", ig_done, 0);
        check("idle_pd", {req_pd, cq_pd, req_vld, cq_vld}, 0);
        check("req_count", got_req.size(), exp_req.size());
        check("cq_count", got_cq.size(), exp_cq.size());
        for (int i = 0; i < got_req.size() && i < exp_req.size(); i++) check("req_entry", 128'(got_req[i]), 128'(exp_req[i]));
        for (int i = 0; i < got_cq.size() && i < exp_cq.size(); i++) check("cq_entry", 128'(got_cq[i]), 128'(exp_cq[i]));
    endtask

    typedef struct packed {
        logic [31:0] hi, lo, ls, ss;
        logic [12:0] w, h, c;
        logic [1:0]  p, mode;
        logic [2:0]  n;
        logic [3:0][78:0] req;
        logic [3:0][13:0] cq;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '0; vt[0].hi = 32'h1; vt[0].lo = 32'h40; vt[0].n = 1;
        vt[0].req[0] = {15'd0, 64'h1_0000_0040}; vt[0].cq[0] = 14'h038;
        vt[1] = '0; vt[1].w = 13'd19; vt[1].n = 3;
        vt[1].req[0] = {15'd7, 64'h000}; vt[1].req[1] = {15'd7, 64'h100}; vt[1].req[2] = {15'd3, 64'h200};
        vt[1].cq[0] = 14'h007; vt[1].cq[1] = 14'h007; vt[1].cq[2] = 14'h03B;
        vt[2] = '0; vt[2].p = 2'd1; vt[2].c = 13'd31; vt[2].h = 13'd1; vt[2].ls = 32'h1000; vt[2].ss = 32'h10000; vt[2].n = 4;
        vt[2].req[0] = {15'd0, 64'h0};     vt[2].req[1] = {15'd0, 64'h1000};
        vt[2].req[2] = {15'd0, 64'h10000}; vt[2].req[3] = {15'd0, 64'h11000};
        vt[2].cq[0] = 14'h008; vt[2].cq[1] = 14'h018; vt[2].cq[2] = 14'h008; vt[2].cq[3] = 14'h038;
        vt[3] = vt[1]; vt[3].mode = 2'd2;
        vt[4] = vt[1]; vt[4].mode = 2'd3;

        #2;
        check("rst_valids", {req_vld, cq_vld, ig_done}, 3'b000);
        check("rst_pd", {req_pd, cq_pd}, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1;

        foreach (vt[k]) begin
            hi = vt[k].hi; lo = vt[k].lo; ls = vt[k].ls; ss = vt[k].ss;
            w = vt[k].w; h = vt[k].h; c = vt[k].c; p = vt[k].p;
            run_job(int'(vt[k].mode), 0);
            check("vec_count", got_req.size(), vt[k].n);
            for (int i = 0; i < int'(vt[k].n) && i < got_req.size() && i < got_cq.size(); i++) begin
                check("vec_req", 128'(got_req[i]), 128'(vt[k].req[i]));
                check("vec_cq", 128'(got_cq[i]), 128'(vt[k].cq[i]));
            end
        end

        for (int k = 0; k < 12; k++) begin
            hi = $urandom; lo = $urandom; ls = $urandom; ss = $urandom;
            w = 13'($urandom_range(0, 20)); h = 13'($urandom_range(0, 3));
            c = 13'($urandom_range(0, 63)); p = 2'($urandom);
            run_job(1, 0);
        end

        hi = 32'h0; lo = 32'h2000; ls = 32'h400; ss = 32'h8000;
        w = 13'd40; h = 13'd3; c = 13'd63; p = 2'd0;
        run_job(0, 1);

        @(posedge clk); #1 op_load = 1; req_rdy = 1; cq_rdy = 1;
        @(posedge clk); #1 op_load = 0;
        repeat (5) @(posedge clk);
        #2 rstn = 0;
        #1 check("async_rst_valids", {req_vld, cq_vld}, 2'b00);
        check("async_rst_pd", {req_pd, cq_pd}, 0);
        @(posedge clk); #1 rstn = 1;
        run_job(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
